// File: rtl/z2_ac_pkg.sv
// Shared definitions for the Zorro II autoconfig engine.
//  - Expansion-ROM register offsets, as seen on ADDR[8:1].
//  - FSM state type.
//  - Helper functions: Zorro II size code and floor(log2).
package z2_ac_pkg;

    localparam logic [7:0] ER_TYPE   = 8'h00;
    localparam logic [7:0] ER_SIZE   = 8'h01;
    localparam logic [7:0] ER_BASE   = 8'h24;
    localparam logic [7:0] ER_SHUTUP = 8'h26;

    // Width of the slot-count arithmetic (capacity, block size, base offset).
    localparam int CAP_W = 8;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        OFFER    = 2'd1,
        WAIT_END = 2'd2,
        DONE     = 2'd3
    } ac_state_e;

    // Zorro II er_Type size field, indexed by log2 of the size in MB.
    function automatic logic [3:0] size_code(input logic [2:0] log2_mb);
        logic [3:0] code;
        case (log2_mb)
            3'd3:    code = 4'h0;
            3'd2:    code = 4'h7;
            3'd1:    code = 4'h6;
            3'd0:    code = 4'h5;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Index of the highest set bit; 0 when the value is 0.
    function automatic logic [2:0] floor_log2(input logic [CAP_W-1:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < CAP_W; i++) begin
            if (v[i]) begin
                r = 3'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/z2_autoconfig_rom.sv
// Combinational autoconfig ROM nibble mux.
// Ports:
//  reg_addr  in  8  register index (bus ADDR[8:1])
//  offer     in  3  log2(MB) of the block currently offered
//  nibble    out 4  value for DBUS[15:12]; everything except er_Type is inverted
module z2_autoconfig_rom
    import z2_ac_pkg::*;
#(
    parameter logic [15:0] MFG_ID  = 16'h07DB,
    parameter logic [7:0]  PROD_ID = 8'h02,
    parameter logic [31:0] SERIAL  = 32'd421
) (
    input  logic [7:0] reg_addr,
    input  logic [2:0] offer,
    output logic [3:0] nibble
);

    // Register index to nibble; unlisted registers read as all ones.
    always_comb begin
        nibble = 4'hF;
        case (reg_addr)
            ER_TYPE: nibble = 4'hE;
            ER_SIZE: nibble = size_code(offer);
            8'h02:   nibble = ~PROD_ID[7:4];
            8'h03:   nibble = ~PROD_ID[3:0];
            8'h04:   nibble = ~4'h8;
            8'h05:   nibble = ~4'h0;
            8'h08:   nibble = ~MFG_ID[15:12];
            8'h09:   nibble = ~MFG_ID[11:8];
            8'h0A:   nibble = ~MFG_ID[7:4];
            8'h0B:   nibble = ~MFG_ID[3:0];
            8'h0C:   nibble = ~SERIAL[31:28];
            8'h0D:   nibble = ~SERIAL[27:24];
            8'h0E:   nibble = ~SERIAL[23:20];
            8'h0F:   nibble = ~SERIAL[19:16];
            8'h10:   nibble = ~SERIAL[15:12];
            8'h11:   nibble = ~SERIAL[11:8];
            8'h12:   nibble = ~SERIAL[7:4];
            8'h13:   nibble = ~SERIAL[3:0];
            default: nibble = 4'hF;
        endcase
    end

endmodule

// File: rtl/z2_autoconfig_multi.sv
// Zorro II autoconfig engine for the FastRAM boards.
// Offers a power-of-two RAM block, shrinks the offer on each shut-up and can
// optionally re-offer leftover capacity. Produces a 1MB slot map of
// $200000-$9FFFFF for the DRAM decoder. Bus strobes are synchronised to CLK.
// Ports:
//  CLK, RESETn            clock, async active-low reset
//  ASn, UDSn, RWn         68k bus strobes / direction (strobes async)
//  CFGINn, CFGOUTn        autoconfig daisy chain
//  ADDR[23:1], DIN[3:0]   bus address, DBUS[15:12] on writes
//  DOUT[3:0], DOUT_EN     read nibble and its tristate enable
//  LIMIT_LOG2[1:0]        capacity jumper, sampled once after reset
//  SLOT_MAP[SLOTS-1:0]    1 = slot decoded as our RAM
//  CONFIGURED, CFG_ERR    block accepted / bad base written (sticky)
module z2_autoconfig_multi
    import z2_ac_pkg::*;
#(
    parameter logic [15:0] MFG_ID      = 16'h07DB,
    parameter logic [7:0]  PROD_ID     = 8'h02,
    parameter logic [31:0] SERIAL      = 32'd421,
    parameter int          MAX_LOG2    = 3,
    parameter int          MIN_LOG2    = 0,
    parameter int          SPLIT_OFFER = 0,
    parameter int          SLOTS       = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             ASn,
    input  logic             UDSn,
    input  logic             RWn,
    input  logic             CFGINn,
    input  logic [23:1]      ADDR,
    input  logic [3:0]       DIN,
    output logic [3:0]       DOUT,
    output logic             DOUT_EN,
    input  logic [1:0]       LIMIT_LOG2,
    output logic             CFGOUTn,
    output logic [SLOTS-1:0] SLOT_MAP,
    output logic             CONFIGURED,
    output logic             CFG_ERR
);

    logic             as_meta_r, as_sync_r;
    logic             uds_meta_r, uds_sync_r, uds_prev_r;
    ac_state_e        state_r, state_nxt_s;
    logic [2:0]       offer_r, offer_nxt_s;
    logic [CAP_W-1:0] cap_r, cap_nxt_s;
    logic [SLOTS-1:0] slot_map_r, slot_map_nxt_s;
    logic             configured_r, configured_nxt_s;
    logic             cfg_err_r, cfg_err_nxt_s;
    logic             cfgout_n_r, cfgout_n_nxt_s;
    logic [3:0]       dout_r, dout_nxt_s;
    logic             dout_en_r, dout_en_nxt_s;
    logic             act_done_r, act_done_nxt_s;

    logic             ac_hit_s, strobe_s;
    logic [7:0]       reg_s;
    logic [2:0]       eff_max_s;
    logic [CAP_W-1:0] size_s, base_off_s, cap_after_s;
    logic             base_ok_s;
    logic [SLOTS-1:0] mask_s;
    logic [3:0]       rom_nibble_s;
    logic             unused_addr_s;

    assign unused_addr_s = ^ADDR[15:9];

    z2_autoconfig_rom #(
        .MFG_ID  (MFG_ID),
        .PROD_ID (PROD_ID),
        .SERIAL  (SERIAL)
    ) u_rom (
        .reg_addr (reg_s),
        .offer    (offer_r),
        .nibble   (rom_nibble_s)
    );

    // Two-flop synchronisers for the bus strobes plus UDSn history for edge detection.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            as_meta_r  <= 1'b1;
            as_sync_r  <= 1'b1;
            uds_meta_r <= 1'b1;
            uds_sync_r <= 1'b1;
            uds_prev_r <= 1'b1;
        end else begin
            as_meta_r  <= ASn;
            as_sync_r  <= as_meta_r;
            uds_meta_r <= UDSn;
            uds_sync_r <= uds_meta_r;
            uds_prev_r <= uds_sync_r;
        end
    end

    // Bus decode, base-address legality and the slot mask of the current offer.
    always_comb begin
        reg_s     = ADDR[8:1];
        // CFGOUTn is still high while we own the chain, so this only hits before DONE.
        ac_hit_s  = (ADDR[23:16] == 8'hE8) && !CFGINn && cfgout_n_r;
        // One action per AS cycle: act_done_r blocks later UDSn falls in the same cycle.
        strobe_s  = uds_prev_r && !uds_sync_r && !as_sync_r && !act_done_r &&
                    ac_hit_s && (state_r == OFFER);
        eff_max_s = (3'(MAX_LOG2) < {1'b0, LIMIT_LOG2}) ? 3'(MAX_LOG2) : {1'b0, LIMIT_LOG2};
        size_s      = 8'd1 << offer_r;
        base_off_s  = {4'd0, DIN} - 8'd2;
        cap_after_s = cap_r - size_s;
        // Base nibbles 0/1 are outside the slot window and are rejected before the wrap.
        base_ok_s   = (DIN >= 4'd2) &&
                      ((base_off_s & (size_s - 8'd1)) == 8'd0) &&
                      ((base_off_s + size_s) <= 8'(SLOTS));
        mask_s = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if ((i >= int'(base_off_s)) && (i < (int'(base_off_s) + int'(size_s)))) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
    end

    // Next-state and next-output logic of the autoconfig FSM.
    always_comb begin
        state_nxt_s      = state_r;
        offer_nxt_s      = offer_r;
        cap_nxt_s        = cap_r;
        slot_map_nxt_s   = slot_map_r;
        configured_nxt_s = configured_r;
        cfg_err_nxt_s    = cfg_err_r;
        cfgout_n_nxt_s   = cfgout_n_r;
        dout_nxt_s       = dout_r;
        dout_en_nxt_s    = ac_hit_s && RWn && !as_sync_r && !uds_sync_r && (state_r == OFFER);

        if (as_sync_r) begin
            act_done_nxt_s = 1'b0;
        end else if (strobe_s) begin
            act_done_nxt_s = 1'b1;
        end else begin
            act_done_nxt_s = act_done_r;
        end

        case (state_r)
            INIT: begin
                cap_nxt_s   = 8'd1 << eff_max_s;
                offer_nxt_s = eff_max_s;
                state_nxt_s = OFFER;
            end
            OFFER: begin
                if (strobe_s && RWn) begin
                    dout_nxt_s = rom_nibble_s;
                end else if (strobe_s && (reg_s == ER_BASE)) begin
                    if (base_ok_s) begin
                        slot_map_nxt_s   = slot_map_r | mask_s;
                        configured_nxt_s = 1'b1;
                    end else begin
                        cfg_err_nxt_s = 1'b1;
                    end
                    // A rejected base still consumes the offer so a split never loops.
                    cap_nxt_s = cap_after_s;
                    if ((SPLIT_OFFER != 0) && (cap_after_s >= (8'd1 << MIN_LOG2))) begin
                        offer_nxt_s = floor_log2(cap_after_s);
                    end else begin
                        state_nxt_s = WAIT_END;
                    end
                end else if (strobe_s && (reg_s == ER_SHUTUP)) begin
                    if (offer_r > 3'(MIN_LOG2)) begin
                        offer_nxt_s = offer_r - 3'd1;
                    end else begin
                        state_nxt_s = WAIT_END;
                    end
                end else begin
                    state_nxt_s = OFFER;
                end
            end
            WAIT_END: begin
                // Level test: a write taken on the same CLK as the AS rise still ends here.
                if (as_sync_r) begin
                    cfgout_n_nxt_s = 1'b0;
                    state_nxt_s    = DONE;
                end else begin
                    state_nxt_s = WAIT_END;
                end
            end
            DONE: begin
                state_nxt_s = DONE;
            end
            default: begin
                state_nxt_s = INIT;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_r      <= INIT;
            offer_r      <= 3'(MAX_LOG2);
            cap_r        <= 8'd1 << MAX_LOG2;
            slot_map_r   <= '0;
            configured_r <= 1'b0;
            cfg_err_r    <= 1'b0;
            cfgout_n_r   <= 1'b1;
            dout_r       <= 4'hF;
            dout_en_r    <= 1'b0;
            act_done_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            offer_r      <= offer_nxt_s;
            cap_r        <= cap_nxt_s;
            slot_map_r   <= slot_map_nxt_s;
            configured_r <= configured_nxt_s;
            cfg_err_r    <= cfg_err_nxt_s;
            cfgout_n_r   <= cfgout_n_nxt_s;
            dout_r       <= dout_nxt_s;
            dout_en_r    <= dout_en_nxt_s;
            act_done_r   <= act_done_nxt_s;
        end
    end

    assign DOUT       = dout_r;
    assign DOUT_EN    = dout_en_r;
    assign CFGOUTn    = cfgout_n_r;
    assign SLOT_MAP   = slot_map_r;
    assign CONFIGURED = configured_r;
    assign CFG_ERR    = cfg_err_r;

endmodule

// File: tb/tb_z2_autoconfig_multi.sv
// Directed bench for z2_autoconfig_multi: one plain instance and one with
// SPLIT_OFFER=1 share the bus; the inactive one has CFGINn held high.
module tb_z2_autoconfig_multi;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        ASn = 1'b1, UDSn = 1'b1, RWn = 1'b1;
    logic        cfgin0_n = 1'b0, cfgin1_n = 1'b1;
    logic [23:1] ADDR = 23'h0;
    logic [3:0]  DIN = 4'h0;
    logic [1:0]  LIMIT_LOG2 = 2'd3;

    logic [3:0]  dout0, dout1;
    logic        en0, en1, cfgout0_n, cfgout1_n, conf0, conf1, err0, err1;
    logic [7:0]  map0, map1;

    logic        sel = 1'b0;
    logic [3:0]  cur_dout;
    logic        cur_en, cur_cfgout_n, cur_conf, cur_err;
    logic [7:0]  cur_map;

    int          total = 0;
    int          bad = 0;
    logic [3:0]  exp_q[$];
    logic        stray_en0 = 1'b0, stray_en1 = 1'b0;

    z2_autoconfig_multi #(.SPLIT_OFFER(0)) u_dut (
        .CLK(CLK), .RESETn(RESETn), .ASn(ASn), .UDSn(UDSn), .RWn(RWn),
        .CFGINn(cfgin0_n), .ADDR(ADDR), .DIN(DIN), .DOUT(dout0), .DOUT_EN(en0),
        .LIMIT_LOG2(LIMIT_LOG2), .CFGOUTn(cfgout0_n), .SLOT_MAP(map0),
        .CONFIGURED(conf0), .CFG_ERR(err0)
    );

    z2_autoconfig_multi #(.SPLIT_OFFER(1)) u_split (
        .CLK(CLK), .RESETn(RESETn), .ASn(ASn), .UDSn(UDSn), .RWn(RWn),
        .CFGINn(cfgin1_n), .ADDR(ADDR), .DIN(DIN), .DOUT(dout1), .DOUT_EN(en1),
        .LIMIT_LOG2(LIMIT_LOG2), .CFGOUTn(cfgout1_n), .SLOT_MAP(map1),
        .CONFIGURED(conf1), .CFG_ERR(err1)
    );

    always #14 CLK = ~CLK;

    assign cur_dout     = sel ? dout1 : dout0;
    assign cur_en       = sel ? en1 : en0;
    assign cur_cfgout_n = sel ? cfgout1_n : cfgout0_n;
    assign cur_conf     = sel ? conf1 : conf0;
    assign cur_err      = sel ? err1 : err0;
    assign cur_map      = sel ? map1 : map0;

    // An instance outside the chain must never drive the bus.
    always @(posedge CLK) begin
        if (en0 && cfgin0_n) stray_en0 <= 1'b1;
        if (en1 && cfgin1_n) stray_en1 <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] lim);
        @(negedge CLK);
        RESETn = 1'b0;
        LIMIT_LOG2 = lim;
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic bus_read(input logic [7:0] r, input logic [3:0] exp, input string tag);
        int n;
        @(negedge CLK);
        ADDR = {8'hE8, 7'h00, r};
        RWn = 1'b1;
        ASn = 1'b0;
        @(negedge CLK);
        UDSn = 1'b0;
        exp_q.push_back(exp);
        n = 0;
        while (!cur_en && (n < 10)) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_en"}, 32'(cur_en), 32'd1);
        check(tag, 32'(cur_dout), 32'(exp_q.pop_front()));
        UDSn = 1'b1;
        ASn = 1'b1;
        repeat (4) @(negedge CLK);
        check({tag, "_en_off"}, 32'(cur_en), 32'd0);
    endtask

    task automatic bus_write(input logic [7:0] r, input logic [3:0] d, input int strobes);
        @(negedge CLK);
        ADDR = {8'hE8, 7'h00, r};
        RWn = 1'b0;
        DIN = d;
        ASn = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < strobes; k++) begin
            UDSn = 1'b0;
            repeat (4) @(negedge CLK);
            UDSn = 1'b1;
            repeat (3) @(negedge CLK);
        end
        ASn = 1'b1;
        RWn = 1'b1;
        repeat (5) @(negedge CLK);
    endtask

    task automatic check_status(input string tag, input logic [7:0] map, input logic cfgout_n,
                                input logic conf, input logic err);
        check({tag, "_map"}, 32'(cur_map), 32'(map));
        check({tag, "_cfgout"}, 32'(cur_cfgout_n), 32'(cfgout_n));
        check({tag, "_conf"}, 32'(cur_conf), 32'(conf));
        check({tag, "_err"}, 32'(cur_err), 32'(err));
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_dout", 32'(dout0), 32'hF);
        check("rst_en", 32'(en0), 32'd0);
        check_status("rst", 8'h00, 1'b1, 1'b0, 1'b0);

        // 1: full 8MB accepted at $200000, ROM contents
        do_reset(2'd3);
        bus_read(8'h00, 4'hE, "t1_type");
        bus_read(8'h01, 4'h0, "t1_size");
        bus_read(8'h02, 4'hF, "t1_prod_hi");
        bus_read(8'h03, 4'hD, "t1_prod_lo");
        bus_read(8'h04, 4'h7, "t1_flags");
        bus_read(8'h05, 4'hF, "t1_rsvd");
        bus_read(8'h06, 4'hF, "t1_other");
        bus_read(8'h09, 4'h8, "t1_mfg1");
        bus_read(8'h0A, 4'h2, "t1_mfg2");
        bus_read(8'h0B, 4'h4, "t1_mfg3");
        bus_read(8'h11, 4'hE, "t1_ser5");
        bus_read(8'h12, 4'h5, "t1_ser6");
        bus_read(8'h13, 4'hA, "t1_ser7");
        bus_write(8'h24, 4'h2, 1);
        check_status("t1", 8'hFF, 1'b0, 1'b1, 1'b0);
        // DONE: no longer answers reads
        @(negedge CLK);
        ASn = 1'b0; RWn = 1'b1; ADDR = {8'hE8, 7'h00, 8'h00};
        @(negedge CLK);
        UDSn = 1'b0;
        repeat (6) @(negedge CLK);
        check("t1_done_no_en", 32'(en0), 32'd0);
        UDSn = 1'b1; ASn = 1'b1;
        repeat (4) @(negedge CLK);

        // 2: shut-up (UDSn pulsed twice in one AS cycle), then 4MB at $600000
        do_reset(2'd3);
        bus_write(8'h26, 4'h0, 2);
        bus_read(8'h01, 4'h7, "t2_size4m");
        check_status("t2_mid", 8'h00, 1'b1, 1'b0, 1'b0);
        bus_write(8'h24, 4'h6, 1);
        check_status("t2", 8'hF0, 1'b0, 1'b1, 1'b0);

        // 3: four shut-ups give up
        do_reset(2'd3);
        for (int i = 0; i < 3; i++) bus_write(8'h26, 4'h0, 1);
        bus_read(8'h01, 4'h5, "t3_size1m");
        bus_write(8'h26, 4'h0, 1);
        check_status("t3", 8'h00, 1'b0, 1'b0, 1'b0);

        // 4: split offers on the second instance
        sel = 1'b1; cfgin0_n = 1'b1; cfgin1_n = 1'b0;
        do_reset(2'd3);
        bus_read(8'h01, 4'h0, "t4_size8m");
        bus_write(8'h26, 4'h0, 1);
        bus_read(8'h01, 4'h7, "t4_size4m");
        bus_write(8'h24, 4'h2, 1);
        check_status("t4_first", 8'h0F, 1'b1, 1'b1, 1'b0);
        bus_read(8'h01, 4'h7, "t4_reoffer");
        bus_write(8'h24, 4'h6, 1);
        check_status("t4", 8'hFF, 1'b0, 1'b1, 1'b0);
        check("t4_idle_map", 32'(map0), 32'h00);
        check("t4_idle_cfgout", 32'(cfgout0_n), 32'd1);
        check("t4_idle_en", 32'(stray_en0), 32'd0);

        // 5: jumper limit 2MB, misaligned base
        sel = 1'b0; cfgin0_n = 1'b0; cfgin1_n = 1'b1;
        do_reset(2'd1);
        bus_read(8'h01, 4'h6, "t5_size2m");
        LIMIT_LOG2 = 2'd3;
        bus_read(8'h01, 4'h6, "t5_lim_held");
        bus_write(8'h24, 4'h3, 1);
        check("t5_map", 32'(map0), 32'h00);
        check("t5_err", 32'(err0), 32'd1);
        check("t5_cfgout", 32'(cfgout0_n), 32'd0);
        check("t5_idle_map", 32'(map1), 32'h00);
        check("t5_idle_cfgout", 32'(cfgout1_n), 32'd1);
        check("t5_idle_en", 32'(stray_en1), 32'd0);

        // 6: reset during a size read
        do_reset(2'd3);
        @(negedge CLK);
        ADDR = {8'hE8, 7'h00, 8'h01}; RWn = 1'b1; ASn = 1'b0;
        @(negedge CLK);
        UDSn = 1'b0;
        n = 0;
        while (!en0 && (n < 10)) begin
            @(negedge CLK);
            n++;
        end
        check("t6_en_before", 32'(en0), 32'd1);
        #3 RESETn = 1'b0;
        #1;
        check("t6_en_async", 32'(en0), 32'd0);
        check("t6_dout_rst", 32'(dout0), 32'hF);
        UDSn = 1'b1; ASn = 1'b1;
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        repeat (3) @(negedge CLK);
        bus_read(8'h01, 4'h0, "t6_size_again");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
